conv_1d_parallel_seq: RTL and testbench
=======================================

Name: conv_1d_parallel_seq

Overview:
- Sequencer for the fully parallel 1D convolution core (flat lines_in/lines_out buses, 8-bit opaque tag pipelined alongside the MAC trees).
- Accepts an image one column per beat over valid/ready and assembles the flat lines_in frame.
- Launches the frame with a unique opaque tag, captures lines_out when the tag returns, then streams results out one column per beat.
- Filling of frame N+1 overlaps draining of frame N.

Parameters:
- DATA_WIDTH, 8, element width.
- IMG_W, 32, input columns per frame.
- IMG_D, 8, input channels.
- FILTER_L, 3, filter length.
- RESULT_D, 8, output channels.
- STRIDE_W, 1, stride.
- RESULT_W, (IMG_W-FILTER_L)/STRIDE_W+1, derived, not set manually.
- FLUSH_CYCLES, 16, cycles after reset with no launch; must be >= core latency.
- WAIT_TIMEOUT, 255, maximum WAIT cycles before error.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low; reset==0 at a clk edge resets the block.
- in_valid  in  1  input column valid.
- in_ready  out  1  input column accepted when in_valid&in_ready.
- in_data  in  DATA_WIDTH*IMG_D  one column; channel k at bits [k*DW +: DW].
- core_lines_in  out  DATA_WIDTH*IMG_D*IMG_W  to core; element (k,w) at index k*IMG_W+w.
- core_opaque_in  out  8  launch tag to core.
- core_lines_out  in  DATA_WIDTH*RESULT_D*RESULT_W  from core; element (i,j) at index i*RESULT_W+j.
- core_opaque_out  in  8  tag returned from core.
- out_valid  out  1  result column valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH*RESULT_D  result column j; channel i at [i*DW +: DW].
- out_last  out  1  high on column RESULT_W-1.
- busy  out  1  high whenever the state is not FILL, or result_full=1, or col_cnt!=0.
- timeout_err  out  1  sticky; cleared only by reset.

Behaviour:
- Tag format: bit7 = valid, bits6:0 = seq. core_opaque_in is 8'h00 in every cycle except FIRE.
- Input FSM states: FLUSH, FILL, FIRE, WAIT.
- FLUSH: entered on reset. flush_cnt counts FLUSH_CYCLES cycles, then the FSM moves to FILL. in_ready=0. Any core_opaque_out seen here is ignored, which drains stale tags from before reset.
- FILL:
  - in_ready=1.
  - Each accepted beat writes column col_cnt of the frame buffer for all channels, then col_cnt increments.
  - On acceptance of column IMG_W-1, col_cnt wraps to 0 and the FSM moves to FIRE.
- FIRE:
  - in_ready=0.
  - If result_full=0, drive core_opaque_in={1'b1,seq} for exactly one cycle, then go to WAIT.
  - If result_full=1, hold in FIRE (frame buffer stable) until the drain completes.
- WAIT:
  - in_ready=0; the frame buffer stays stable; wait_cnt increments.
  - When core_opaque_out=={1'b1,seq}: capture core_lines_out into the result buffer, set result_full=1, increment seq (mod 128), go to FILL.
  - If wait_cnt reaches WAIT_TIMEOUT: set timeout_err=1 and go to FILL without capturing. The frame is dropped and seq still increments.
  - A non-matching tag is ignored.
- Drain side:
  - out_valid = result_full.
  - out_data = column drain_cnt of the result buffer.
  - On out_valid&out_ready, drain_cnt increments.
  - At drain_cnt==RESULT_W-1 (out_last=1), drain_cnt wraps to 0 and result_full clears.
  - out_data is held stable while out_valid=1 and out_ready=0.
- Simultaneous events:
  - A capture cannot coincide with result_full=1, because launch is gated in FIRE.
  - FIRE sees result_full clear in the same cycle as the last drain handshake, so launch happens the next cycle; no combinational bypass.
- Latency:
  - Tag launch to capture equals the core pipeline depth.
  - Capture to first out_valid is 1 cycle.
  - The last input beat to launch is 1 cycle when result_full=0.
- Reset values:
  - in_ready=0, out_valid=0, out_last=0, core_opaque_in=0, timeout_err=0.
  - busy=1 (the FSM is in FLUSH).
  - seq=0; all counters 0.
  - Buffers are not reset; the core_lines_in value is don't-care until the first FIRE.
- Reset mid-frame: a partial fill, pending result, or in-flight tag is discarded. No out_valid is asserted until a new full frame has completed.

Decomposition:
- Package conv_1d_seq_pkg holds:
  - state enum {FLUSH, FILL, FIRE, WAIT};
  - TAG_VALID_BIT=7;
  - the tag typedef (valid + 7-bit seq).
- One natural sub-module: conv_1d_result_drain. It holds the result buffer, result_full, drain_cnt, out_valid/out_ready/out_last, and a capture strobe input.

Test Plan:
Bench config for all scenarios: DW=8, IMG_W=4, IMG_D=2, FILTER_L=3, RESULT_D=2 (RESULT_W=2), FLUSH_CYCLES=4. A behavioural core model uses 3-cycle latency.
- Reset then an idle bench:
  - in_ready=0 for 4 cycles, then 1.
  - core_opaque_in stays 0; out_valid=0.
- Input columns {ch1,ch0} = {1,1},{2,2},{3,3},{4,4}, all weights 1:
  - FIRE tag 8'h80.
  - Capture 3 cycles later.
  - Output column 0 = {12,12} = 1+2+3 summed over 2 channels; column 1 = {18,18}; out_last on column 1.
- Two back-to-back frames with out_ready held 0:
  - The second frame fills; FIRE holds and tag 8'h81 is not launched until both columns of frame 0 have drained.
- Random out_ready stalls: out_data holds stable during every stall; there is no loss or duplication.
- Core model never returns the tag:
  - timeout_err=1 after 255 WAIT cycles; the FSM returns to FILL.
  - The next frame uses tag 8'h81.
- Reset asserted in WAIT while a stale tag 8'h80 emerges during FLUSH: it is ignored, out_valid stays 0, and the next launch uses tag 8'h80.

Source files
------------

// File: rtl/conv_1d_parallel_seq_pkg.sv
// Shared types for the 1D convolution sequencer: FSM state codes and launch tag layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_1d_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t FLUSH = 2'd0;
    localparam state_t FILL  = 2'd1;
    localparam state_t FIRE  = 2'd2;
    localparam state_t WAIT  = 2'd3;

    localparam int TAG_VALID_BIT = 7;

    // Opaque tag carried through the core pipeline: valid flag plus 7-bit sequence number.
    typedef struct packed {
        logic       vld;
        logic [6:0] seq;
    } tag_t;

    // Counter width that stays legal when the count range is a single value.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_1d_parallel_seq_if.sv
// Column streams into and out of the convolution sequencer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the input and the output stream.
interface conv_1d_parallel_seq_if #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_D      = 8,
    parameter int RESULT_D   = 8
);
    logic                           in_valid;
    logic                           in_ready;
    logic [DATA_WIDTH*IMG_D-1:0]    in_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [DATA_WIDTH*RESULT_D-1:0] out_data;
    logic                           out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv_1d_result_drain.sv
// Result buffer: captures a full core output frame and streams it out one column per beat.
// Latency: capture strobe to out_valid is 1 cycle.
// Backpressure: out_data/out_last held while out_valid && !out_ready; result_full gates next launch.
module conv_1d_result_drain
    import conv_1d_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RESULT_D   = 8,
    parameter int RESULT_W   = 30
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    capture,
    input  logic [DATA_WIDTH*RESULT_D*RESULT_W-1:0] lines,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [DATA_WIDTH*RESULT_D-1:0]          out_data,
    output logic                                    out_last,
    output logic                                    result_full
);
    localparam int              DCW      = cnt_w(RESULT_W);
    localparam logic [DCW-1:0]  LAST_COL = DCW'(RESULT_W - 1);

    logic [DATA_WIDTH*RESULT_D*RESULT_W-1:0] result_q, result_d;
    logic                                    full_q, full_d;
    logic [DCW-1:0]                          drain_cnt_q, drain_cnt_d;

    // Capture loads the buffer; each accepted beat advances the column, the last one frees it.
    always_comb begin
        result_d    = capture ? lines : result_q;
        full_d      = full_q;
        drain_cnt_d = drain_cnt_q;
        if (capture) begin
            full_d = 1'b1;
        end else if (full_q && out_ready) begin
            if (drain_cnt_q == LAST_COL) begin
                drain_cnt_d = '0;
                full_d      = 1'b0;
            end else begin
                drain_cnt_d = drain_cnt_q + 1'b1;
            end
        end
    end

    // Control state; reset discards any pending result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            full_q      <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            full_q      <= full_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Result storage is data only and needs no reset.
    always_ff @(posedge clk) begin
        result_q <= result_d;
    end

    // Gather channel i of the current column j from element index i*RESULT_W+j.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < RESULT_D; i++) begin
            out_data[i*DATA_WIDTH +: DATA_WIDTH] =
                result_q[(i*RESULT_W + int'(drain_cnt_q))*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign out_valid   = full_q;
    assign out_last    = full_q && (drain_cnt_q == LAST_COL);
    assign result_full = full_q;

endmodule

// File: rtl/conv_1d_parallel_seq.sv
// Sequencer for the fully parallel 1D conv core: fills a frame, launches it with a tag, drains the result.
// Latency: last input beat to launch 1 cycle; launch to capture = core depth; capture to out_valid 1 cycle.
// Backpressure: in_ready low outside FILL; launch held in FIRE while the previous result is still draining.
module conv_1d_parallel_seq
    import conv_1d_seq_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int IMG_W        = 32,
    parameter int IMG_D        = 8,
    parameter int FILTER_L     = 3,
    parameter int RESULT_D     = 8,
    parameter int STRIDE_W     = 1,
    parameter int FLUSH_CYCLES = 16,
    parameter int WAIT_TIMEOUT = 255,
    localparam int RESULT_W    = (IMG_W - FILTER_L) / STRIDE_W + 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    conv_1d_parallel_seq_if.slave                   io,
    output logic [DATA_WIDTH*IMG_D*IMG_W-1:0]       core_lines_in,
    output logic [7:0]                              core_opaque_in,
    input  logic [DATA_WIDTH*RESULT_D*RESULT_W-1:0] core_lines_out,
    input  logic [7:0]                              core_opaque_out,
    output logic                                    busy,
    output logic                                    timeout_err
);
    localparam int              FCW        = cnt_w(FLUSH_CYCLES);
    localparam int              CW         = cnt_w(IMG_W);
    localparam int              WCW        = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [FCW-1:0]  FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0]   COL_LAST   = CW'(IMG_W - 1);
    localparam logic [WCW-1:0]  WAIT_LAST  = WCW'(WAIT_TIMEOUT - 1);

    state_t                             state_q, state_d;
    logic [FCW-1:0]                     flush_cnt_q, flush_cnt_d;
    logic [CW-1:0]                      col_cnt_q, col_cnt_d;
    logic [WCW-1:0]                     wait_cnt_q, wait_cnt_d;
    logic [6:0]                         seq_q, seq_d;
    logic                               timeout_err_q, timeout_err_d;
    logic [DATA_WIDTH*IMG_D*IMG_W-1:0]  frame_q, frame_d;
    logic                               capture;
    logic                               result_full;
    tag_t                               my_tag;

    assign my_tag.vld = 1'b1;
    assign my_tag.seq = seq_q;

    // Input FSM: flush stale tags, fill columns, launch when the result buffer is free, await the tag.
    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        col_cnt_d      = col_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        seq_d          = seq_q;
        timeout_err_d  = timeout_err_q;
        frame_d        = frame_q;
        capture        = 1'b0;
        core_opaque_in = 8'h00;
        io.in_ready    = 1'b0;
        case (state_q)
            FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    flush_cnt_d = '0;
                    state_d     = FILL;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            FILL: begin
                io.in_ready = 1'b1;
                if (io.in_valid) begin
                    for (int k = 0; k < IMG_D; k++) begin
                        frame_d[(k*IMG_W + int'(col_cnt_q))*DATA_WIDTH +: DATA_WIDTH] =
                            io.in_data[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                    if (col_cnt_q == COL_LAST) begin
                        col_cnt_d = '0;
                        state_d   = FIRE;
                    end else begin
                        col_cnt_d = col_cnt_q + 1'b1;
                    end
                end
            end
            FIRE: begin
                if (!result_full) begin
                    core_opaque_in = my_tag;
                    wait_cnt_d     = '0;
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                if (core_opaque_out[TAG_VALID_BIT] && (core_opaque_out == my_tag)) begin
                    capture = 1'b1;
                    seq_d   = seq_q + 1'b1;
                    state_d = FILL;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_err_d = 1'b1;
                    seq_d         = seq_q + 1'b1;
                    state_d       = FILL;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = FLUSH;
        endcase
    end

    // Control registers; reset drops any partial fill or in-flight tag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= FLUSH;
            flush_cnt_q   <= '0;
            col_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            seq_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            col_cnt_q     <= col_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            seq_q         <= seq_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Frame buffer is data only; its contents are irrelevant until the first launch.
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    conv_1d_result_drain #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESULT_D   (RESULT_D),
        .RESULT_W   (RESULT_W)
    ) u_drain (
        .clk         (clk),
        .reset       (reset),
        .capture     (capture),
        .lines       (core_lines_out),
        .out_valid   (io.out_valid),
        .out_ready   (io.out_ready),
        .out_data    (io.out_data),
        .out_last    (io.out_last),
        .result_full (result_full)
    );

    assign core_lines_in = frame_q;
    assign timeout_err   = timeout_err_q;
    assign busy          = (state_q != FILL) || result_full || (col_cnt_q != '0);

endmodule

// File: tb/tb_conv_1d_parallel_seq.sv
// Directed bench for conv_1d_parallel_seq with a 3-cycle behavioural core (all weights 1).
// Latency: n/a.
// Backpressure: exercises stalled, randomly stalled and free-running output.
module tb_conv_1d_parallel_seq;
    localparam int DW = 8, IW = 4, ID = 2, FL = 3, RD = 2, RW = 2, FC = 4, WT = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b0;

    conv_1d_parallel_seq_if #(.DATA_WIDTH(DW), .IMG_D(ID), .RESULT_D(RD)) bus();

    logic [DW*ID*IW-1:0] lines_in;
    logic [7:0]          opq_in;
    logic [DW*RD*RW-1:0] lines_out;
    logic [7:0]          opq_out;
    logic                busy, terr;

    conv_1d_parallel_seq #(
        .DATA_WIDTH(DW), .IMG_W(IW), .IMG_D(ID), .FILTER_L(FL), .RESULT_D(RD),
        .STRIDE_W(1), .FLUSH_CYCLES(FC), .WAIT_TIMEOUT(WT)
    ) dut (
        .clk(clk), .reset(reset), .io(bus),
        .core_lines_in(lines_in), .core_opaque_in(opq_in),
        .core_lines_out(lines_out), .core_opaque_out(opq_out),
        .busy(busy), .timeout_err(terr)
    );

    // Behavioural core: 3-cycle pipeline, not reset, so stale tags survive a sequencer reset.
    logic [7:0]          p_tag0 = 8'h00, p_tag1 = 8'h00, p_tag2 = 8'h00;
    logic [DW*RD*RW-1:0] p_res0 = '0, p_res1 = '0, p_res2 = '0;
    bit                  core_drop = 1'b0;

    function automatic logic [DW*RD*RW-1:0] core_conv(input logic [DW*ID*IW-1:0] f);
        logic [DW*RD*RW-1:0] r;
        logic [DW-1:0]       s;
        r = '0;
        for (int i = 0; i < RD; i++)
            for (int j = 0; j < RW; j++) begin
                s = '0;
                for (int k = 0; k < ID; k++)
                    for (int t = 0; t < FL; t++)
                        s = s + f[(k*IW + j + t)*DW +: DW];
                r[(i*RW + j)*DW +: DW] = s;
            end
        return r;
    endfunction

    always @(posedge clk) begin
        p_tag0 <= opq_in;  p_res0 <= core_conv(lines_in);
        p_tag1 <= p_tag0;  p_res1 <= p_res0;
        p_tag2 <= p_tag1;  p_res2 <= p_res1;
    end
    assign opq_out   = core_drop ? 8'h00 : p_tag2;
    assign lines_out = p_res2;

    // Monitor: records output beats, launched tags, input handshakes and stall stability.
    int          cyc = 0;
    logic [15:0] beat_q[$];
    bit          last_q[$];
    int          beat_cyc[$];
    logic [7:0]  tag_q[$];
    int          tag_cyc[$];
    int          in_cyc_last = 0;
    int          stall_viol = 0, stall_seen = 0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    int          passed = 0, total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            if (bus.out_valid && bus.out_ready) begin
                beat_q.push_back(bus.out_data);
                last_q.push_back(bus.out_last);
                beat_cyc.push_back(cyc);
            end
            if (opq_in != 8'h00) begin
                tag_q.push_back(opq_in);
                tag_cyc.push_back(cyc);
            end
            if (bus.in_valid && bus.in_ready) in_cyc_last = cyc;
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) stall_viol++;
            if (bus.out_valid && !bus.out_ready) stall_seen++;
        end
        prev_stall = reset && bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
    end

    localparam logic [31:0] FA = 32'h04030201;  // columns 1,2,3,4
    localparam logic [31:0] FB0 = 32'h0D0C0B0A; // ch0 columns 10..13
    localparam logic [31:0] FB1 = 32'h03020100; // ch1 columns 0..3

    task automatic clear_logs;
        beat_q.delete(); last_q.delete(); beat_cyc.delete();
        tag_q.delete(); tag_cyc.delete();
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        reset = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1; core_drop = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        clear_logs();
    endtask

    task automatic send_frame(input logic [31:0] ch0, input logic [31:0] ch1, output bit ok);
        int n;
        ok = 1'b1;
        for (int w = 0; w < IW; w++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.in_data  = {ch1[w*8 +: 8], ch0[w*8 +: 8]};
            n = 0;
            @(negedge clk);
            while (!bus.in_ready && n < 400) begin
                @(negedge clk);
                n++;
            end
            if (n >= 400) begin
                ok = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (beat_q.size() < n && k < 600) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_tags(input int n);
        int k = 0;
        while (tag_q.size() < n && k < 600) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset;
        do_reset();
        for (int i = 0; i < FC; i++) begin
            @(negedge clk);
            total++; if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready c%0d: got %b want 0", i, bus.in_ready); else passed++;
            total++; if (opq_in !== 8'h00) $display("FAIL flush_tag c%0d: got %h want 00", i, opq_in); else passed++;
            total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_out_valid c%0d: got %b want 0", i, bus.out_valid); else passed++;
            total++; if (busy !== 1'b1) $display("FAIL flush_busy c%0d: got %b want 1", i, busy); else passed++;
        end
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) $display("FAIL fill_in_ready: got %b want 1", bus.in_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passed++;
        total++; if (terr !== 1'b0) $display("FAIL reset_timeout_err: got %b want 0", terr); else passed++;
        total++; if (bus.out_last !== 1'b0) $display("FAIL reset_out_last: got %b want 0", bus.out_last); else passed++;
        repeat (10) @(negedge clk);
        total++; if (tag_q.size() != 0) $display("FAIL idle_no_launch: got %0d tags want 0", tag_q.size()); else passed++;
    endtask

    task automatic test_single_frame;
        bit ok;
        do_reset();
        send_frame(FA, FA, ok);
        total++; if (ok !== 1'b1) $display("FAIL single_send: got %b want 1", ok); else passed++;
        wait_tags(1);
        total++; if (tag_q[0] !== 8'h80) $display("FAIL single_tag: got %h want 80", tag_q[0]); else passed++;
        total++; if (tag_cyc[0] - in_cyc_last != 1) $display("FAIL last_beat_to_launch: got %0d want 1", tag_cyc[0] - in_cyc_last); else passed++;
        wait_beats(2);
        total++; if (beat_cyc[0] - tag_cyc[0] != 4) $display("FAIL launch_to_out_valid: got %0d want 4", beat_cyc[0] - tag_cyc[0]); else passed++;
        total++; if (beat_q[0] !== 16'h0C0C) $display("FAIL single_col0: got %h want 0c0c", beat_q[0]); else passed++;
        total++; if (last_q[0] !== 1'b0) $display("FAIL single_last0: got %b want 0", last_q[0]); else passed++;
        total++; if (beat_q[1] !== 16'h1212) $display("FAIL single_col1: got %h want 1212", beat_q[1]); else passed++;
        total++; if (last_q[1] !== 1'b1) $display("FAIL single_last1: got %b want 1", last_q[1]); else passed++;
        repeat (5) @(negedge clk);
        total++; if (beat_q.size() != 2) $display("FAIL single_beat_count: got %0d want 2", beat_q.size()); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else passed++;
    endtask

    task automatic test_back_to_back;
        bit ok_a, ok_b;
        do_reset();
        bus.out_ready = 1'b0;
        send_frame(FA, FA, ok_a);
        send_frame(FB0, FB1, ok_b);
        total++; if ((ok_a && ok_b) !== 1'b1) $display("FAIL b2b_send: got %b%b want 11", ok_a, ok_b); else passed++;
        repeat (20) @(negedge clk);
        total++; if (tag_q.size() != 1) $display("FAIL b2b_held_tags: got %0d want 1", tag_q.size()); else passed++;
        total++; if (tag_q[0] !== 8'h80) $display("FAIL b2b_tag0: got %h want 80", tag_q[0]); else passed++;
        total++; if (bus.out_valid !== 1'b1) $display("FAIL b2b_out_valid: got %b want 1", bus.out_valid); else passed++;
        total++; if (bus.out_data !== 16'h0C0C) $display("FAIL b2b_held_data: got %h want 0c0c", bus.out_data); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", busy); else passed++;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_beats(4);
        wait_tags(2);
        total++; if (tag_q[1] !== 8'h81) $display("FAIL b2b_tag1: got %h want 81", tag_q[1]); else passed++;
        total++; if (tag_cyc[1] - beat_cyc[1] != 1) $display("FAIL b2b_launch_after_drain: got %0d want 1", tag_cyc[1] - beat_cyc[1]); else passed++;
        total++; if (beat_q[1] !== 16'h1212 || last_q[1] !== 1'b1) $display("FAIL b2b_a_col1: got %h/%b want 1212/1", beat_q[1], last_q[1]); else passed++;
        total++; if (beat_q[2] !== 16'h2424 || last_q[2] !== 1'b0) $display("FAIL b2b_b_col0: got %h/%b want 2424/0", beat_q[2], last_q[2]); else passed++;
        total++; if (beat_q[3] !== 16'h2A2A || last_q[3] !== 1'b1) $display("FAIL b2b_b_col1: got %h/%b want 2a2a/1", beat_q[3], last_q[3]); else passed++;
    endtask

    task automatic test_stall;
        bit ok_a, ok_b;
        do_reset();
        stall_viol = 0;
        stall_seen = 0;
        fork
            begin
                send_frame(FA, FA, ok_a);
                send_frame(FB0, FB1, ok_b);
            end
            begin
                repeat (120) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 2) == 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_beats(4);
        repeat (10) @(negedge clk);
        total++; if ((ok_a && ok_b) !== 1'b1) $display("FAIL stall_send: got %b%b want 11", ok_a, ok_b); else passed++;
        total++; if (beat_q.size() != 4) $display("FAIL stall_beat_count: got %0d want 4", beat_q.size()); else passed++;
        total++; if (stall_viol != 0) $display("FAIL stall_stability: got %0d violations want 0", stall_viol); else passed++;
        total++; if (stall_seen == 0) $display("FAIL stall_exercised: got %0d stalls want >0", stall_seen); else passed++;
        total++; if (beat_q[0] !== 16'h0C0C) $display("FAIL stall_b0: got %h want 0c0c", beat_q[0]); else passed++;
        total++; if (beat_q[1] !== 16'h1212) $display("FAIL stall_b1: got %h want 1212", beat_q[1]); else passed++;
        total++; if (beat_q[2] !== 16'h2424) $display("FAIL stall_b2: got %h want 2424", beat_q[2]); else passed++;
        total++; if (beat_q[3] !== 16'h2A2A) $display("FAIL stall_b3: got %h want 2a2a", beat_q[3]); else passed++;
    endtask

    task automatic test_timeout;
        bit ok;
        int n, err_cyc;
        do_reset();
        core_drop = 1'b1;
        send_frame(FA, FA, ok);
        wait_tags(1);
        total++; if (tag_q[0] !== 8'h80) $display("FAIL to_tag0: got %h want 80", tag_q[0]); else passed++;
        n = 0;
        while (terr !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        err_cyc = cyc;
        total++; if (terr !== 1'b1) $display("FAIL to_err_set: got %b want 1", terr); else passed++;
        // One FIRE cycle plus 255 WAIT cycles separate the launch sample from the first error sample.
        total++; if (err_cyc - tag_cyc[0] != 256) $display("FAIL to_err_timing: got %0d want 256", err_cyc - tag_cyc[0]); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL to_back_to_fill: got %b want 1", bus.in_ready); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL to_no_result: got %b want 0", bus.out_valid); else passed++;
        core_drop = 1'b0;
        send_frame(FB0, FB1, ok);
        wait_tags(2);
        wait_beats(2);
        total++; if (tag_q[1] !== 8'h81) $display("FAIL to_next_tag: got %h want 81", tag_q[1]); else passed++;
        total++; if (beat_q[0] !== 16'h2424 || beat_q[1] !== 16'h2A2A) $display("FAIL to_next_data: got %h %h want 2424 2a2a", beat_q[0], beat_q[1]); else passed++;
        total++; if (terr !== 1'b1) $display("FAIL to_sticky: got %b want 1", terr); else passed++;
    endtask

    task automatic test_reset_stale;
        bit ok;
        int n, ov_cnt, stale_cnt;
        do_reset();
        send_frame(FA, FA, ok);
        n = 0;
        while (opq_in !== 8'h80 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++; if (opq_in !== 8'h80) $display("FAIL stale_first_launch: got %h want 80", opq_in); else passed++;
        do_reset();
        ov_cnt = 0;
        stale_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) ov_cnt++;
            if (opq_out == 8'h80) stale_cnt++;
        end
        total++; if (stale_cnt == 0) $display("FAIL stale_tag_seen: got %0d want >0", stale_cnt); else passed++;
        total++; if (ov_cnt != 0) $display("FAIL stale_out_valid: got %0d cycles want 0", ov_cnt); else passed++;
        total++; if (tag_q.size() != 0) $display("FAIL stale_no_relaunch: got %0d want 0", tag_q.size()); else passed++;
        send_frame(FB0, FB1, ok);
        wait_tags(1);
        wait_beats(2);
        total++; if (tag_q[0] !== 8'h80) $display("FAIL stale_next_tag: got %h want 80", tag_q[0]); else passed++;
        total++; if (beat_q[0] !== 16'h2424 || beat_q[1] !== 16'h2A2A) $display("FAIL stale_next_data: got %h %h want 2424 2a2a", beat_q[0], beat_q[1]); else passed++;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall();
        test_timeout();
        test_reset_stale();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
